// File: rtl/lpc_wb_regfile_arbiter_if.sv
// Bus bundle for the LPC/Wishbone register-file arbiter: LPC requester, Wishbone slave
// and single-port register-file signals. slave = arbiter view, master = environment view.
interface lpc_wb_regfile_arbiter_if #(
    parameter int ADDR_W = 8
);
    // LPC requester (already in the WB_CLK domain)
    logic              lpc_req;
    logic              lpc_we;
    logic [ADDR_W-1:0] lpc_addr;
    logic [7:0]        lpc_wdata;
    logic [7:0]        lpc_rdata;
    logic              lpc_done;

    // Wishbone slave, 8-bit data
    logic              WBs_CYC;
    logic              WBs_STB;
    logic              WBs_WE;
    logic [ADDR_W-1:0] WBs_ADR;
    logic [7:0]        WBs_WR_DAT;
    logic [7:0]        WBs_RD_DAT;
    logic              WBs_ACK;

    // Single-port register file, read data one cycle after mem_en
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  lpc_req, lpc_we, lpc_addr, lpc_wdata,
        output lpc_rdata, lpc_done,
        input  WBs_CYC, WBs_STB, WBs_WE, WBs_ADR, WBs_WR_DAT,
        output WBs_RD_DAT, WBs_ACK,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output lpc_req, lpc_we, lpc_addr, lpc_wdata,
        input  lpc_rdata, lpc_done,
        output WBs_CYC, WBs_STB, WBs_WE, WBs_ADR, WBs_WR_DAT,
        input  WBs_RD_DAT, WBs_ACK,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lpc_wb_regfile_arbiter.sv
// Round-robin arbiter sharing one single-port register file between an LPC requester and a
// Wishbone slave. Define LPC_WB_ARB_INTR_EN to enable the LPC-write interrupt (lpc_wr_intr).
module lpc_wb_regfile_arbiter #(
    parameter int                ADDR_W        = 8,
    parameter logic [ADDR_W-1:0] INTR_CLR_ADDR = 8'hFF
) (
    input  logic                           WB_CLK,
    input  logic                           WB_RST_n,
    lpc_wb_regfile_arbiter_if.slave        bus,
    output logic                           lpc_wr_intr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic              last_wb_q,   last_wb_d;    // 1: WB was granted last
    logic              gnt_lpc_q,   gnt_lpc_d;
    logic              we_q,        we_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              lpc_done_q,  lpc_done_d;
    logic              wb_ack_q,    wb_ack_d;
    logic [7:0]        lpc_rdata_q, lpc_rdata_d;
    logic [7:0]        wb_rdata_q,  wb_rdata_d;

    // Request qualifiers; lpc_req_q is combinational despite its name, masking the
    // completion cycle so a held request is not seen twice.
    logic wb_req;
    logic lpc_req_q;
    logic pick_lpc;

    assign wb_req    = bus.WBs_CYC & bus.WBs_STB & ~bus.WBs_ACK;
    assign lpc_req_q = bus.lpc_req & ~bus.lpc_done;
    assign pick_lpc  = lpc_req_q & (~wb_req | last_wb_q);

    always_comb begin
        state_d     = state_q;
        last_wb_d   = last_wb_q;
        gnt_lpc_d   = gnt_lpc_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lpc_done_d  = 1'b0;
        wb_ack_d    = 1'b0;
        lpc_rdata_d = lpc_rdata_q;
        wb_rdata_d  = wb_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (lpc_req_q || wb_req) begin
                    gnt_lpc_d   = pick_lpc;
                    last_wb_d   = ~pick_lpc;
                    we_d        = pick_lpc ? bus.lpc_we    : bus.WBs_WE;
                    mem_addr_d  = pick_lpc ? bus.lpc_addr  : bus.WBs_ADR;
                    mem_wdata_d = pick_lpc ? bus.lpc_wdata : bus.WBs_WR_DAT;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_d;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                lpc_done_d = gnt_lpc_q;
                wb_ack_d   = ~gnt_lpc_q;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (gnt_lpc_q) lpc_rdata_d = bus.mem_rdata;
                else           wb_rdata_d  = bus.mem_rdata;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            state_q     <= S_IDLE;
            last_wb_q   <= 1'b1;
            gnt_lpc_q   <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lpc_done_q  <= 1'b0;
            wb_ack_q    <= 1'b0;
            lpc_rdata_q <= '0;
            wb_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_wb_q   <= last_wb_d;
            gnt_lpc_q   <= gnt_lpc_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lpc_done_q  <= lpc_done_d;
            wb_ack_q    <= wb_ack_d;
            lpc_rdata_q <= lpc_rdata_d;
            wb_rdata_q  <= wb_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.lpc_done  = lpc_done_q;
    assign bus.WBs_ACK   = wb_ack_q;

    // Read data is live during the response pulse, then held until that side's next response
    assign bus.lpc_rdata  = lpc_done_q ? bus.mem_rdata : lpc_rdata_q;
    assign bus.WBs_RD_DAT = wb_ack_q   ? bus.mem_rdata : wb_rdata_q;

`ifdef LPC_WB_ARB_INTR_EN
    logic intr_q, intr_d;
    logic intr_set, intr_clr;

    assign intr_set = (state_q == S_RESP) & gnt_lpc_q & we_q;
    assign intr_clr = (state_q == S_RESP) & ~gnt_lpc_q & we_q &
                      (mem_addr_q == INTR_CLR_ADDR) & mem_wdata_q[0];

    always_comb begin
        intr_d = intr_q;
        if (intr_set)      intr_d = 1'b1;
        else if (intr_clr) intr_d = 1'b0;
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) intr_q <= 1'b0;
        else           intr_q <= intr_d;
    end

    assign lpc_wr_intr = intr_q;
`else
    assign lpc_wr_intr = 1'b0;
`endif

endmodule

// File: tb/tb_lpc_wb_regfile_arbiter.sv
// Directed bench for lpc_wb_regfile_arbiter with a behavioural register file; expected
// interrupt behaviour follows LPC_WB_ARB_INTR_EN.
module tb_lpc_wb_regfile_arbiter;

`ifdef LPC_WB_ARB_INTR_EN
    localparam logic INTR_ON = 1'b1;
`else
    localparam logic INTR_ON = 1'b0;
`endif

    logic WB_CLK = 1'b0;
    logic WB_RST_n;
    logic lpc_wr_intr;
    int   checks   = 0;
    int   failures = 0;

    lpc_wb_regfile_arbiter_if #(.ADDR_W(8)) bus ();

    lpc_wb_regfile_arbiter #(.ADDR_W(8), .INTR_CLR_ADDR(8'hFF)) dut (
        .WB_CLK      (WB_CLK),
        .WB_RST_n    (WB_RST_n),
        .bus         (bus),
        .lpc_wr_intr (lpc_wr_intr)
    );

    always #5 WB_CLK = ~WB_CLK;

    // Register file model: read-first, data valid the cycle after mem_en
    logic [7:0] mem [0:255];
    always @(posedge WB_CLK) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge WB_CLK);
        #1;
    endtask

    task automatic do_reset();
        WB_RST_n = 1'b0;
        #1;
        chk("rst_outs", {bus.mem_en, bus.mem_we, bus.lpc_done, bus.WBs_ACK, lpc_wr_intr}, 0);
        chk("rst_bus",  {bus.mem_addr, bus.mem_wdata, bus.lpc_rdata, bus.WBs_RD_DAT}, 0);
        @(negedge WB_CLK);
        WB_RST_n = 1'b1;
        tick();
    endtask

    // Sole-requester LPC transaction starting in IDLE
    task automatic lpc_xact(input string tag, input logic we, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] exp_rd);
        bus.lpc_req = 1'b1; bus.lpc_we = we; bus.lpc_addr = a; bus.lpc_wdata = d;
        tick();
        chk({tag, "_c1"}, {bus.mem_en, bus.mem_we, bus.mem_addr, bus.lpc_done}, {1'b1, we, a, 1'b0});
        if (we) chk({tag, "_wd"}, bus.mem_wdata, d);
        tick();
        chk({tag, "_c2"}, {bus.lpc_done, bus.mem_en, bus.WBs_ACK}, 3'b100);
        if (!we) chk({tag, "_rd"}, bus.lpc_rdata, exp_rd);
        bus.lpc_req = 1'b0;
        tick();
        chk({tag, "_c3"}, {bus.lpc_done, bus.mem_en}, 2'b00);
    endtask

    // Sole-requester WB transaction starting in IDLE
    task automatic wb_xact(input string tag, input logic we, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd);
        bus.WBs_CYC = 1'b1; bus.WBs_STB = 1'b1; bus.WBs_WE = we; bus.WBs_ADR = a; bus.WBs_WR_DAT = d;
        tick();
        chk({tag, "_c1"}, {bus.mem_en, bus.mem_we, bus.mem_addr, bus.WBs_ACK}, {1'b1, we, a, 1'b0});
        tick();
        chk({tag, "_c2"}, {bus.WBs_ACK, bus.mem_en, bus.lpc_done}, 3'b100);
        if (!we) chk({tag, "_rd"}, bus.WBs_RD_DAT, exp_rd);
        bus.WBs_CYC = 1'b0; bus.WBs_STB = 1'b0;
        tick();
        chk({tag, "_c3"}, {bus.WBs_ACK, bus.mem_en}, 2'b00);
        if (!we) chk({tag, "_hold"}, bus.WBs_RD_DAT, exp_rd);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.lpc_req = 0; bus.lpc_we = 0; bus.lpc_addr = 0; bus.lpc_wdata = 0;
        bus.WBs_CYC = 0; bus.WBs_STB = 0; bus.WBs_WE = 0; bus.WBs_ADR = 0; bus.WBs_WR_DAT = 0;
        WB_RST_n = 1'b1;
        #2;
        do_reset();

        // LPC write then WB readback
        lpc_xact("lpc_wr10", 1'b1, 8'h10, 8'hA5, 8'h00);
        chk("intr_set", lpc_wr_intr, INTR_ON);
        wb_xact("wb_rd10", 1'b0, 8'h10, 8'h00, 8'hA5);

        // Interrupt clear: bit0=0 keeps it, bit0=1 clears it, memory still written
        wb_xact("wb_wrff_00", 1'b1, 8'hFF, 8'h00, 8'h00);
        chk("intr_keep", lpc_wr_intr, INTR_ON);
        wb_xact("wb_wrff_01", 1'b1, 8'hFF, 8'h01, 8'h00);
        chk("intr_clr", lpc_wr_intr, 1'b0);
        wb_xact("wb_rdff", 1'b0, 8'hFF, 8'h00, 8'h01);

        // Contention after reset: LPC first, WB next, then LPC alone, then WB first
        do_reset();
        bus.lpc_req = 1; bus.lpc_we = 1; bus.lpc_addr = 8'h20; bus.lpc_wdata = 8'h11;
        bus.WBs_CYC = 1; bus.WBs_STB = 1; bus.WBs_WE = 1; bus.WBs_ADR = 8'h30; bus.WBs_WR_DAT = 8'h22;
        tick();
        chk("ct_c1", {bus.mem_en, bus.mem_addr}, {1'b1, 8'h20});
        tick();
        chk("ct_c2", {bus.lpc_done, bus.WBs_ACK}, 2'b10);
        tick();
        chk("ct_c3", {bus.mem_en, bus.lpc_done, bus.WBs_ACK}, 3'b000);
        tick();
        chk("ct_c4", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {2'b11, 8'h30, 8'h22});
        tick();
        chk("ct_c5", {bus.WBs_ACK, bus.lpc_done}, 2'b10);
        bus.WBs_CYC = 0; bus.WBs_STB = 0;
        tick();
        tick();
        chk("ct_c7", {bus.mem_en, bus.mem_addr}, {1'b1, 8'h20});
        tick();
        chk("ct_c8", {bus.lpc_done, bus.WBs_ACK}, 2'b10);
        bus.lpc_req = 0;
        tick();
        bus.lpc_req = 1; bus.lpc_we = 0; bus.lpc_addr = 8'h30;
        bus.WBs_CYC = 1; bus.WBs_STB = 1; bus.WBs_WE = 0; bus.WBs_ADR = 8'h20;
        tick();
        chk("ct2_c1", {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b10, 8'h20});
        tick();
        chk("ct2_c2", {bus.WBs_ACK, bus.lpc_done, bus.WBs_RD_DAT}, {2'b10, 8'h11});
        bus.WBs_CYC = 0; bus.WBs_STB = 0;
        tick();
        tick();
        chk("ct2_c4", {bus.mem_en, bus.mem_addr}, {1'b1, 8'h30});
        tick();
        chk("ct2_c5", {bus.lpc_done, bus.lpc_rdata}, {1'b1, 8'h22});
        bus.lpc_req = 0;
        tick();
        chk("ct2_hold", {bus.lpc_done, bus.lpc_rdata}, {1'b0, 8'h22});

        // Request dropped right after grant still completes
        bus.WBs_CYC = 1; bus.WBs_STB = 1; bus.WBs_WE = 1; bus.WBs_ADR = 8'h50; bus.WBs_WR_DAT = 8'h33;
        tick();
        bus.WBs_CYC = 0; bus.WBs_STB = 0;
        chk("drop_c1", {bus.mem_en, bus.mem_addr}, {1'b1, 8'h50});
        tick();
        chk("drop_c2", bus.WBs_ACK, 1'b1);
        tick();
        chk("drop_mem", mem[8'h50], 8'h33);

        // Reset during ACCESS of an LPC write discards it
        bus.lpc_req = 1; bus.lpc_we = 1; bus.lpc_addr = 8'h40; bus.lpc_wdata = 8'h77;
        tick();
        chk("mid_c1", {bus.mem_en, bus.mem_addr}, {1'b1, 8'h40});
        #1;
        WB_RST_n = 1'b0;
        bus.lpc_req = 0;
        #1;
        chk("mid_rst", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.lpc_done}, 0);
        @(negedge WB_CLK);
        WB_RST_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.mem_en || bus.lpc_done || bus.WBs_ACK || lpc_wr_intr) seen++;
        end
        chk("mid_quiet", seen, 0);
        chk("mid_nowrite", mem[8'h40], 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lpc_wb_regfile_arbiter.md
LPC_WB_REGFILE_ARBITER -- requirements
Module: lpc_wb_regfile_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the register-file address width.
REQ-002 SHALL have parameter INTR_CLR_ADDR, default 8'hFF, giving the WB address whose write clears the interrupt.
REQ-003 SHALL have port WB_CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port WB_RST_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports for the LPC requester, already synchronized into WB_CLK:
- lpc_req, input, 1: request, held until lpc_done.
- lpc_we, input, 1: write strobe.
- lpc_addr, input, ADDR_W: address.
- lpc_wdata, input, 8: write data.
- lpc_rdata, output, 8: read data.
- lpc_done, output, 1: one-cycle completion pulse.
REQ-006 SHALL have ports for the Wishbone slave:
- WBs_CYC, input, 1.
- WBs_STB, input, 1.
- WBs_WE, input, 1.
- WBs_ADR, input, ADDR_W.
- WBs_WR_DAT, input, 8.
- WBs_RD_DAT, output, 8.
- WBs_ACK, output, 1: one-cycle pulse.
REQ-007 SHALL have ports for the single-port register file:
- mem_en, output, 1.
- mem_we, output, 1.
- mem_addr, output, ADDR_W.
- mem_wdata, output, 8.
- mem_rdata, input, 8: valid the cycle after mem_en.
REQ-008 SHALL have port lpc_wr_intr, output, 1: level interrupt to FPGA_INTR[0].

Function
REQ-009 wb_req SHALL be defined as WBs_CYC & WBs_STB & ~WBs_ACK; lpc_req_q SHALL be defined as lpc_req & ~lpc_done.
REQ-010 FSM SHALL have states IDLE, ACCESS and RESP, sequenced IDLE -> ACCESS -> RESP -> IDLE, with ACCESS and RESP lasting exactly one cycle each.
REQ-011 In IDLE with any request present, SHALL latch the winner's we/addr/wdata and a grant flag, then enter ACCESS.
REQ-012 Arbitration SHALL be round-robin:
- With both requesting, grant goes to the requester not granted last.
- last_grant resets to WB, so LPC wins the first contention.
- A sole requester is always granted.
REQ-013 In ACCESS, mem_en SHALL be 1; mem_we/mem_addr/mem_wdata SHALL drive the latched values. mem_en SHALL be 0 in every other state.
REQ-014 In RESP, SHALL pulse lpc_done or WBs_ACK (granted side only) for one cycle, with lpc_rdata or WBs_RD_DAT equal to mem_rdata. Read data SHALL hold until the next RESP for that side.
REQ-015 Latency from request sampled in IDLE (cycle 0) SHALL be: mem_en at cycle 1, done/ACK at cycle 2. Back-to-back grant SHALL be possible at cycle 3.
REQ-016 A requester dropping its request after grant SHALL NOT abort the transaction; the access and pulse still occur.
REQ-017 The losing requester SHALL wait with no timeout. Maximum wait is one transaction (3 cycles) under continuous contention.
REQ-018 Address and data width SHALL pass through unchanged; the upper WBs data bits are not present.

Reset
REQ-019 WB_RST_n low SHALL asynchronously force:
- state = IDLE, last_grant = WB.
- lpc_done, WBs_ACK, mem_en, mem_we, lpc_wr_intr = 0.
- mem_addr, mem_wdata, lpc_rdata, WBs_RD_DAT = 0.
REQ-020 Reset asserted mid-transaction SHALL discard it: no mem_en, done or ACK after release until a fresh request is sampled in IDLE.
REQ-021 Reset release SHALL take effect on the first WB_CLK edge after deassertion.

Configuration
REQ-022 Macro LPC_WB_ARB_INTR_EN SHALL control the interrupt feature.
- Defined: lpc_wr_intr sets at the cycle following the RESP of an LPC write.
- Defined: lpc_wr_intr clears at the cycle following the RESP of a WB write to INTR_CLR_ADDR with WBs_WR_DAT[0]=1; that write also updates memory normally.
- Defined: set has priority over clear in the same cycle.
- Undefined: lpc_wr_intr is constant 0 and no interrupt register exists.

Verification
REQ-023 LPC write addr 8'h10 data 8'hA5, no WB activity -> mem_en/mem_we=1 at cycle 1 with mem_addr 8'h10, lpc_done pulse at cycle 2; with macro, lpc_wr_intr=1 from cycle 3.
REQ-024 WB read addr 8'h10 after the above -> WBs_ACK at cycle 2, WBs_RD_DAT=8'hA5, exactly one ACK cycle.
REQ-025 LPC and WB requests asserted in the same cycle and held, after reset -> LPC granted first, WB granted at cycle 3, WB ACK at cycle 5; next contention grants WB first.
REQ-026 WB write 8'hFF data 8'h01 while lpc_wr_intr=1 -> lpc_wr_intr=0 the cycle after ACK; data 8'h00 -> stays 1; without macro -> always 0.
REQ-027 WB_RST_n pulsed low during ACCESS of an LPC write -> outputs 0 immediately, no lpc_done issued, no further mem_en until a new request.
